// File: rtl/dcf77_encoder.sv
// DCF77 time-code encoder.
//
// Builds a 59-bit DCF77 frame from BCD time/date inputs and keys it out as a
// pulse-width modulated carrier-reduction signal, one bit per second.
// Bit 0 is a short pulse, bit 1 a long pulse, and the final second of the
// minute carries no pulse (minute marker).
//
// Optional feature macro: DCF77_LEAP_SECOND_EN
//   When defined, adds input leap_second. A frame loaded with leap_second=1
//   carries bit 19 = 1 and lasts 61 s. Second 59 is a 0-bit pulse and second
//   60 is the pulse-free marker.
//
// Ports:
//   clk          clock
//   reset        asynchronous active-low reset
//   clk_en       10 ms tick enable; all state advances only on these cycles
//   tx_en        transmit enable; 0 holds the encoder idle and silent
//   dst          1 = CEST, 0 = CET
//   year, month, day, hour, minute
//                BCD pairs, [1] = tens digit, [0] = units digit
//   day_of_week  1..7
//   leap_second  (DCF77_LEAP_SECOND_EN only) leap second announced
//   dcf77_tx     1 = carrier reduced (registered)
//   frame_load   one-clk strobe after the time inputs were sampled
//   second_idx   current second within the frame, binary
module dcf77_encoder #(
    parameter int unsigned TICKS_PER_SECOND = 100,
    parameter int unsigned PULSE0_TICKS     = 10,
    parameter int unsigned PULSE1_TICKS     = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_en,
    input  logic            tx_en,
    input  logic            dst,
    input  logic [1:0][3:0] year,
    input  logic [1:0][3:0] month,
    input  logic [1:0][3:0] day,
    input  logic [2:0]      day_of_week,
    input  logic [1:0][3:0] hour,
    input  logic [1:0][3:0] minute,
`ifdef DCF77_LEAP_SECOND_EN
    input  logic            leap_second,
`endif
    output logic            dcf77_tx,
    output logic            frame_load,
    output logic [5:0]      second_idx
);

    localparam int unsigned TickW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_SECOND - 1);

    // StLoad is held for the single clk following the sampling edge; the
    // load itself happens on the clk_en that leaves StIdle or wraps second 59.
    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [5:0]       sec_q, sec_d;
    logic [58:0]      frame_q, frame_d, frame_new;
    logic             tx_q, tx_d;
    logic             load, advance;
    logic [5:0]       last_sec;
    logic [63:0]      frame_pad;
    int unsigned      pulse_len;

    // Tens-digit bits that no DCF77 field carries.
    logic unused_bits;
    assign unused_bits = ^{minute[1][3], hour[1][3:2], day[1][3:2], month[1][3:1]};

    // Bit 19 of the running frame doubles as the leap-frame flag.
    assign last_sec = frame_q[19] ? 6'd60 : 6'd59;

    // Frame assembly from the live inputs; only captured on load.
    always_comb begin
        frame_new        = '0;
        frame_new[17]    = dst;
        frame_new[18]    = ~dst;
`ifdef DCF77_LEAP_SECOND_EN
        frame_new[19]    = leap_second;
`else
        frame_new[19]    = 1'b0;
`endif
        frame_new[20]    = 1'b1;
        frame_new[24:21] = minute[0];
        frame_new[27:25] = minute[1][2:0];
        frame_new[28]    = ^{minute[1][2:0], minute[0]};
        frame_new[32:29] = hour[0];
        frame_new[34:33] = hour[1][1:0];
        frame_new[35]    = ^{hour[1][1:0], hour[0]};
        frame_new[39:36] = day[0];
        frame_new[41:40] = day[1][1:0];
        frame_new[44:42] = day_of_week;
        frame_new[48:45] = month[0];
        frame_new[49]    = month[1][0];
        frame_new[53:50] = year[0];
        frame_new[57:54] = year[1];
        frame_new[58]    = ^frame_new[57:36];
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        if (!tx_en) begin
            state_d = StIdle;
        end else if (clk_en) begin
            case (state_q)
                StIdle: load = 1'b1;
                StLoad, StSend: begin
                    advance = 1'b1;
                    load    = (tick_q == TickLast) && (sec_q == last_sec);
                end
                default: load = 1'b0;
            endcase
            state_d = load ? StLoad : StSend;
        end else if (state_q == StLoad) begin
            state_d = StSend;
        end
    end

    // Output logic.
    always_comb begin
        dcf77_tx   = tx_q;
        frame_load = (state_q == StLoad) && tx_en;
        second_idx = sec_q;
    end

    // Datapath next state: tick/second counters, frame capture and pulse.
    always_comb begin
        tick_d    = tick_q;
        sec_d     = sec_q;
        frame_d   = frame_q;
        tx_d      = tx_q;
        frame_pad = '0;
        pulse_len = 0;
        if (!tx_en) begin
            tick_d = '0;
            sec_d  = '0;
            tx_d   = 1'b0;
        end else if (load || advance) begin
            if (load) begin
                tick_d  = '0;
                sec_d   = '0;
                frame_d = frame_new;
            end else if (tick_q == TickLast) begin
                tick_d = '0;
                sec_d  = sec_q + 6'd1;
            end else begin
                tick_d = tick_q + TickW'(1);
            end
            // Pulse decision uses the tick/second being entered so the
            // registered output rises on the edge where tick becomes 0.
            frame_pad = {5'b0, frame_d};
            if (sec_d < 6'd59) begin
                pulse_len = frame_pad[sec_d] ? PULSE1_TICKS : PULSE0_TICKS;
            end else if ((sec_d == 6'd59) && frame_d[19]) begin
                pulse_len = PULSE0_TICKS;
            end else begin
                pulse_len = 0;
            end
            tx_d = (32'(tick_d) < pulse_len);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q  <= '0;
            sec_q   <= '0;
            frame_q <= '0;
            tx_q    <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            sec_q   <= sec_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
        end
    end

endmodule
